// File: rtl/ser_harness_pkg.sv
// ser_harness_pkg: FSM state enums, frame length and counter-width helper.
// FRAME_BITS is 10 (8N1), or 11 when SER_HARNESS_PARITY_EN is defined.
package ser_harness_pkg;

   typedef enum logic [1:0] {
      SEQ_PRE,
      SEQ_ASSERT,
      SEQ_RUN
   } seq_state_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } ser_state_t;

`ifdef SER_HARNESS_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   // Bits needed to hold values 0..n.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ser_harness_fifo.sv
// ser_harness_fifo: first-word fall-through FIFO with sticky overflow.
// Ports: clk, reset (sync, high), push/push_data, pop/pop_data, empty, full, overflow.
module ser_harness_fifo
   import ser_harness_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             full_q;
   logic             ovf_q;
   logic             do_pop;
   logic             do_push;

   assign empty    = (wptr == rptr) && !full_q;
   assign full     = full_q;
   assign overflow = ovf_q;
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot a push needs when full.
   assign do_push  = push && (!full_q || do_pop);
   assign pop_data = empty ? '0 : mem[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr   <= '0;
         rptr   <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_push)
            wptr <= wptr + AW'(1);
         if (do_pop)
            rptr <= rptr + AW'(1);
         if (do_push && !do_pop && ((wptr + AW'(1)) == rptr))
            full_q <= 1'b1;
         else if (do_pop && !do_push)
            full_q <= 1'b0;
         if (push && !do_push)
            ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= push_data;
   end

endmodule

// File: rtl/ser_harness.sv
// ser_harness: DUT reset sequencer, UART stimulus/capture and watchdog.
// Ports: clk, reset; dut_reset_l, dut_rx, dut_tx; tx_valid/tx_data/tx_ready;
// rd_en/rd_data/rd_empty; running, frame_err, overflow, timeout.
// Define SER_HARNESS_PARITY_EN for even-parity frames in both directions.
module ser_harness
   import ser_harness_pkg::*;
#(
   parameter int BAUD_DIV       = 16,
   parameter int PRE_CYCLES     = 4,
   parameter int RST_CYCLES     = 4,
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       reset,
   output logic       dut_reset_l,
   output logic       dut_rx,
   input  logic       dut_tx,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_empty,
   output logic       running,
   output logic       frame_err,
   output logic       overflow,
   output logic       timeout
);

   localparam int SEQ_MAX = (PRE_CYCLES > RST_CYCLES) ? PRE_CYCLES : RST_CYCLES;
   localparam int SW      = cnt_w(SEQ_MAX);
   localparam int BW      = cnt_w(BAUD_DIV);
   localparam int DBITS   = FRAME_BITS - 2;
   localparam int NW      = cnt_w(DBITS);
   localparam int WW      = cnt_w(TIMEOUT_CYCLES);

   localparam logic [SW-1:0] PRE_LAST  = SW'(PRE_CYCLES - 1);
   localparam logic [SW-1:0] RST_LAST  = SW'(RST_CYCLES - 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [NW-1:0] BIT_LAST  = NW'(DBITS - 1);
   localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

   // Reset sequencer
   seq_state_t    seq_q, seq_d;
   logic [SW-1:0] seq_cnt_q, seq_cnt_d;
   logic          run_enter;

   always_ff @(posedge clk) begin
      if (reset) begin
         seq_q     <= SEQ_PRE;
         seq_cnt_q <= '0;
      end else begin
         seq_q     <= seq_d;
         seq_cnt_q <= seq_cnt_d;
      end
   end

   always_comb begin
      seq_d     = seq_q;
      seq_cnt_d = seq_cnt_q + SW'(1);
      unique case (seq_q)
         SEQ_PRE:
            if (seq_cnt_q == PRE_LAST) begin
               seq_d     = SEQ_ASSERT;
               seq_cnt_d = '0;
            end
         SEQ_ASSERT:
            if (seq_cnt_q == RST_LAST) begin
               seq_d     = SEQ_RUN;
               seq_cnt_d = '0;
            end
         SEQ_RUN:
            seq_cnt_d = '0;
         default: begin
            seq_d     = SEQ_PRE;
            seq_cnt_d = '0;
         end
      endcase
   end

   assign dut_reset_l = (seq_q != SEQ_ASSERT);
   assign running     = (seq_q == SEQ_RUN);
   assign run_enter   = (seq_q == SEQ_ASSERT) && (seq_d == SEQ_RUN);

   // TX serialiser
   ser_state_t       tx_q, tx_d;
   logic [BW-1:0]    tx_cnt_q, tx_cnt_d;
   logic [NW-1:0]    tx_bit_q, tx_bit_d;
   logic [DBITS-1:0] tx_sh_q, tx_sh_d;
   logic [DBITS-1:0] tx_load;

`ifdef SER_HARNESS_PARITY_EN
   assign tx_load = {^tx_data, tx_data};
`else
   assign tx_load = tx_data;
`endif

   assign tx_ready = running && (tx_q == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_q     <= S_IDLE;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
      end else begin
         tx_q     <= tx_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
      end
   end

   always_comb begin
      tx_d     = tx_q;
      tx_cnt_d = tx_cnt_q + BW'(1);
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      dut_rx   = 1'b1;
      unique case (tx_q)
         S_IDLE: begin
            tx_cnt_d = '0;
            if (tx_valid && tx_ready) begin
               tx_d    = S_START;
               tx_sh_d = tx_load;
            end
         end
         S_START: begin
            dut_rx = 1'b0;
            if (tx_cnt_q == BAUD_LAST) begin
               tx_d     = S_DATA;
               tx_cnt_d = '0;
               tx_bit_d = '0;
            end
         end
         S_DATA: begin
            dut_rx = tx_sh_q[0];
            if (tx_cnt_q == BAUD_LAST) begin
               tx_cnt_d = '0;
               tx_sh_d  = tx_sh_q >> 1;
               tx_bit_d = tx_bit_q + NW'(1);
               if (tx_bit_q == BIT_LAST)
                  tx_d = S_STOP;
            end
         end
         S_STOP:
            if (tx_cnt_q == BAUD_LAST) begin
               tx_d     = S_IDLE;
               tx_cnt_d = '0;
            end
         default:
            tx_d = S_IDLE;
      endcase
   end

   // RX deserialiser
   logic             rx_s1, rx_s2, rx_prev;
   ser_state_t       rx_q, rx_d;
   logic [BW-1:0]    rx_cnt_q, rx_cnt_d;
   logic [NW-1:0]    rx_bit_q, rx_bit_d;
   logic [DBITS-1:0] rx_sh_q, rx_sh_d;
   logic             rx_bad;
   logic             push_d, push_q;
   logic             ferr_set;
   logic             ferr_q;
   logic [7:0]       byte_q;

`ifdef SER_HARNESS_PARITY_EN
   assign rx_bad = !rx_s2 || (^rx_sh_q);
`else
   assign rx_bad = !rx_s2;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_q     <= S_IDLE;
         rx_cnt_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
         push_q   <= 1'b0;
         byte_q   <= '0;
         ferr_q   <= 1'b0;
      end else begin
         rx_s1    <= dut_tx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_q     <= rx_d;
         rx_cnt_q <= rx_cnt_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
         push_q   <= push_d;
         if (push_d)
            byte_q <= rx_sh_q[7:0];
         if (ferr_set)
            ferr_q <= 1'b1;
      end
   end

   always_comb begin
      rx_d     = rx_q;
      rx_cnt_d = rx_cnt_q + BW'(1);
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      push_d   = 1'b0;
      ferr_set = 1'b0;
      unique case (rx_q)
         S_IDLE: begin
            rx_cnt_d = '0;
            // Edge is seen one cycle after it leaves the synchroniser,
            // so the half-bit count starts at 1.
            if (running && rx_prev && !rx_s2) begin
               rx_d     = S_START;
               rx_cnt_d = BW'(1);
            end
         end
         S_START:
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_d     = rx_s2 ? S_IDLE : S_DATA;
            end
         S_DATA:
            if (rx_cnt_q == BAUD_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2, rx_sh_q[DBITS-1:1]};
               rx_bit_d = rx_bit_q + NW'(1);
               if (rx_bit_q == BIT_LAST)
                  rx_d = S_STOP;
            end
         S_STOP:
            if (rx_cnt_q == BAUD_LAST) begin
               rx_d     = S_IDLE;
               rx_cnt_d = '0;
               ferr_set = rx_bad;
               push_d   = !rx_bad;
            end
         default:
            rx_d = S_IDLE;
      endcase
   end

   assign frame_err = ferr_q;

   // Capture FIFO
   logic fifo_full;
   logic push_ok;

   ser_harness_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_q),
      .push_data (byte_q),
      .pop       (rd_en),
      .pop_data  (rd_data),
      .empty     (rd_empty),
      .full      (fifo_full),
      .overflow  (overflow)
   );

   assign push_ok = push_q && (!fifo_full || (rd_en && !rd_empty));

   // Watchdog
   logic [WW-1:0] wd_q;
   logic          to_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q <= '0;
         to_q <= 1'b0;
      end else if (run_enter || push_ok) begin
         wd_q <= '0;
      end else if (running && (wd_q != WD_MAX)) begin
         wd_q <= wd_q + WW'(1);
         if (wd_q == WD_LAST)
            to_q <= 1'b1;
      end
   end

   assign timeout = to_q;

endmodule

// File: tb/tb_ser_harness.sv
// tb_ser_harness: self-checking bench for ser_harness (BAUD_DIV=16,
// TIMEOUT_CYCLES=1000); table vectors, hand sequences, random RX/TX.
module tb_ser_harness;

   localparam int B = 16;
`ifdef SER_HARNESS_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   // Edges from dut_tx start-bit change to rd_empty low:
   // stop sample at (FB-1.5)*B+B+2, push one cycle later.
   localparam int LAT   = (FB - 1) * B + B / 2 + 3;
   localparam int POP_E = LAT - 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dut_tx = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       rd_en = 1'b0;
   logic       dut_reset_l, dut_rx, tx_ready;
   logic [7:0] rd_data;
   logic       rd_empty, running, frame_err, overflow, timeout;

   ser_harness #(
      .BAUD_DIV       (B),
      .PRE_CYCLES     (4),
      .RST_CYCLES     (4),
      .DEPTH          (16),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .dut_reset_l (dut_reset_l),
      .dut_rx      (dut_rx),
      .dut_tx      (dut_tx),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_empty    (rd_empty),
      .running     (running),
      .frame_err   (frame_err),
      .overflow    (overflow),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [7:0] d;
      bit         stop;
      bit         pbad;
      bit         glitch;
      bit         exp_push;
      bit         exp_ferr;
   } vec_t;

   vec_t vt[$];

   // Frame as the line should carry it: start, LSB-first data,
   // optional even parity, stop.
   function automatic logic [10:0] frame_bits(input logic [7:0] d,
                                              input bit stop, input bit pbad);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (FB == 11) begin
         f[9]  = (^d) ^ pbad;
         f[10] = stop;
      end else begin
         f[9] = stop;
      end
      return f;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; tx_valid = 1'b0; rd_en = 1'b0; dut_tx = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (9) @(posedge clk);
      #1;
   endtask

   // Drives one frame on dut_tx; pulses rd_en at iteration pop_e;
   // reports the first iteration at which rd_empty was seen low.
   task automatic drive_frame(input logic [7:0] d, input bit stop,
                              input bit pbad, input int pop_e,
                              output int first_ne);
      logic [10:0] f;
      f = frame_bits(d, stop, pbad);
      first_ne = -1;
      for (int e = 0; e < FB * B; e++) begin
         if (first_ne < 0 && !rd_empty) first_ne = e;
         dut_tx = f[e / B];
         rd_en  = (e == pop_e);
         @(posedge clk); #1;
      end
      rd_en  = 1'b0;
      dut_tx = 1'b1;
      if (first_ne < 0 && !rd_empty) first_ne = FB * B;
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   // Sends a byte through the TX side and watches dut_rx.
   task automatic capture_tx(input logic [7:0] d, output int mism,
                             output int low, output logic rdy_after,
                             output logic [7:0] dec);
      logic [10:0] f;
      int w;
      w = 0;
      while (!tx_ready && w < 5000) begin
         @(posedge clk); #1;
         w++;
      end
      check("tx_ready_wait", tx_ready, 1);
      f = frame_bits(d, 1'b1, 1'b0);
      tx_valid = 1'b1; tx_data = d;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      mism = 0; low = 0; dec = '0;
      for (int c = 0; c < FB * B; c++) begin
         if (dut_rx !== f[c / B]) mism++;
         if (!tx_ready) low++;
         if ((c % B) == B / 2 && c / B >= 1 && c / B <= 8)
            dec[c / B - 1] = dut_rx;
         @(posedge clk); #1;
      end
      rdy_after = tx_ready;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fne, mism, low;
      logic rdy;
      logic [7:0] dec, d, e;
      logic [7:0] q[$];
      bit exp_ferr, good;
      int npop;

      // Reset values, with a stimulus byte offered that must be ignored
      tx_valid = 1'b1; tx_data = 8'h0F;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dut_reset_l", dut_reset_l, 1);
      check("rst_dut_rx", dut_rx, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_running", running, 0);
      check("rst_rd_empty", rd_empty, 1);
      check("rst_rd_data", rd_data, 0);
      check("rst_flags", {frame_err, overflow, timeout}, 0);

      // Reset sequence, then watchdog with no RX traffic
      reset = 1'b0;
      for (int k = 0; k <= 1008; k++) begin
         if (k < 10) begin
            check($sformatf("seq_reset_l_c%0d", k), dut_reset_l, (k < 4 || k >= 8));
            check($sformatf("seq_running_c%0d", k), running, (k >= 8));
            check($sformatf("seq_dut_rx_c%0d", k), dut_rx, 1);
         end
         if (k == 7) tx_valid = 1'b0;
         if (k == 9) check("ready_in_run", tx_ready, 1);
         if (k == 1007) check("wd_before", timeout, 0);
         if (k == 1008) check("wd_expire", timeout, 1);
         @(posedge clk); #1;
      end

      // Table-driven RX vectors
      vt.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      vt.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef SER_HARNESS_PARITY_EN
      vt.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      vt.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
`endif
      foreach (vt[i]) begin
         do_reset();
         check($sformatf("v%0d_timeout_clr", i), timeout, 0);
         if (vt[i].glitch) begin
            dut_tx = 1'b0;
            repeat (4) @(posedge clk);
            #1 dut_tx = 1'b1;
            repeat (3 * B) @(posedge clk);
            #1;
         end else begin
            drive_frame(vt[i].d, vt[i].stop, vt[i].pbad, -1, fne);
         end
         check($sformatf("v%0d_empty", i), rd_empty, !vt[i].exp_push);
         check($sformatf("v%0d_frame_err", i), frame_err, vt[i].exp_ferr);
         if (vt[i].exp_push) begin
            check($sformatf("v%0d_rd_data", i), rd_data, vt[i].d);
            check($sformatf("v%0d_latency", i), fne, LAT);
            pop_one();
            check($sformatf("v%0d_empty_after_pop", i), rd_empty, 1);
         end
      end

      // TX frame 0xA5
      capture_tx(8'hA5, mism, low, rdy, dec);
      check("tx_a5_line", mism, 0);
      check("tx_a5_ready_low", low, FB * B);
      check("tx_a5_ready_back", rdy, 1);
      check("tx_a5_decode", dec, 8'hA5);

      // Random TX bytes, decoded at mid-bit
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         capture_tx(d, mism, low, rdy, dec);
         check($sformatf("tx_rand%0d_decode", i), dec, d);
         check($sformatf("tx_rand%0d_line", i), mism, 0);
      end

      // Random RX stream against a queue model
      do_reset();
      exp_ferr = 1'b0;
      for (int i = 0; i < 24; i++) begin
         d    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 4) != 0);
         drive_frame(d, good, 1'b0, -1, fne);
         if (good) q.push_back(d);
         else exp_ferr = 1'b1;
         npop = $urandom_range(0, q.size());
         if (q.size() >= 12) npop = q.size();
         for (int p = 0; p < npop; p++) begin
            e = q.pop_front();
            check($sformatf("rx_rand%0d_data", i), rd_data, e);
            pop_one();
         end
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1;
      end
      check("rx_rand_frame_err", frame_err, exp_ferr);
      check("rx_rand_overflow", overflow, 0);
      check("rx_rand_empty", rd_empty, (q.size() == 0));

      // Overflow: 17 bytes with no pops
      do_reset();
      for (int i = 0; i <= 16; i++)
         drive_frame(8'(i), 1'b1, 1'b0, -1, fne);
      check("ovf_set", overflow, 1);
      mism = 0;
      for (int i = 0; i < 16; i++) begin
         if (rd_data !== 8'(i)) mism++;
         pop_one();
      end
      check("ovf_pop_order", mism, 0);
      check("ovf_drained", rd_empty, 1);

      // Reset clears sticky flags and FIFO
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst2_overflow", overflow, 0);
      check("rst2_frame_err", frame_err, 0);
      check("rst2_running", running, 0);
      check("rst2_rd_empty", rd_empty, 1);
      check("rst2_rd_data", rd_data, 0);

      // Full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 16; i++)
         drive_frame(8'(i), 1'b1, 1'b0, -1, fne);
      check("full_no_ovf", overflow, 0);
      drive_frame(8'h99, 1'b1, 1'b0, POP_E, fne);
      check("full_pushpop_ovf", overflow, 0);
      check("full_pushpop_head", rd_data, 8'h01);
      mism = 0;
      for (int i = 1; i <= 16; i++) begin
         if (rd_data !== ((i == 16) ? 8'h99 : 8'(i))) mism++;
         pop_one();
      end
      check("full_pushpop_order", mism, 0);
      check("full_pushpop_empty", rd_empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
